// File: rtl/softmax_norm_pkg.sv
// rtl/softmax_norm_pkg.sv - shared constants, types and helpers for softmax_norm
// Purpose: widths, exp word layout, FSM state type and the linearisation helper.
// Ports: none (package).
package softmax_pkg;
   localparam int N_MAX  = 16;
   localparam int MANT_W = 16;
   localparam int POS_W  = 5;
   localparam int OUT_W  = 16;
   localparam int WORD_W = POS_W + MANT_W;
   localparam int LIN_W  = MANT_W + (1 << POS_W) - 1;
   localparam int IDX_W  = $clog2(N_MAX);
   localparam int ACC_W  = LIN_W + IDX_W;
   localparam int CNT_W  = IDX_W + 1;
   localparam int DVD_W  = LIN_W + OUT_W;
   localparam int Q_W    = OUT_W + 1;

   typedef struct packed {
      logic [POS_W-1:0]  pos;
      logic [MANT_W-1:0] mant;
   } exp_word_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DIVIDE,
      ST_EMIT
   } norm_state_e;

   function automatic logic [LIN_W-1:0] lin_of(exp_word_t w);
      return LIN_W'(w.mant) << w.pos;
   endfunction
endpackage

// File: rtl/softmax_norm_if.sv
// rtl/softmax_norm_if.sv - input/output stream bundle for softmax_norm
// Purpose: groups the exp-word input stream and the probability output stream.
// Ports: none; signals in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_data/out_last.
//   slave  : the normaliser (consumes in_*, produces out_*).
//   master : the producer/consumer around it.
interface softmax_norm_if;
   import softmax_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/softmax_norm_divider.sv
// rtl/softmax_norm_divider.sv - unsigned sequential restoring divider
// Purpose: produces Q_W quotient bits, one per cycle, after a start pulse.
//   The caller guarantees the quotient fits in Q_W bits (dividend high part < divisor).
// Ports: clk, rst (sync active-high, clears run/done), i_start (load operands),
//   i_dividend, i_divisor, o_done (one-cycle pulse), o_quotient (valid with o_done).
module seq_divider #(
   parameter int DVD_W = 63,
   parameter int DSR_W = 51,
   parameter int Q_W   = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [DVD_W-1:0] i_dividend,
   input  logic [DSR_W-1:0] i_divisor,
   output logic             o_done,
   output logic [Q_W-1:0]   o_quotient
);
   localparam int CW = $clog2(Q_W + 1);

   logic [DSR_W-1:0] r_rem;
   logic [DSR_W-1:0] r_dsr;
   // Low dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [Q_W-1:0]   r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_run;
   logic             r_done;

   logic [DSR_W:0]   w_trial;
   logic [DSR_W-1:0] w_diff;
   logic             w_ge;

   assign w_trial = {r_rem, r_q[Q_W-1]};
   assign w_ge    = w_trial >= {1'b0, r_dsr};
   // The true difference is below the divisor, so the low bits are exact.
   assign w_diff  = w_trial[DSR_W-1:0] - r_dsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem  <= '0;
         r_dsr  <= '0;
         r_q    <= '0;
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_rem <= DSR_W'(i_dividend[DVD_W-1:Q_W]);
            r_q   <= i_dividend[Q_W-1:0];
            r_dsr <= i_divisor;
            r_cnt <= CW'(Q_W);
            r_run <= 1'b1;
         end else if (r_run) begin
            r_rem <= w_ge ? w_diff : w_trial[DSR_W-1:0];
            r_q   <= {r_q[Q_W-2:0], w_ge};
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done     = r_done;
   assign o_quotient = r_q;
endmodule

// File: rtl/softmax_norm.sv
// rtl/softmax_norm.sv - softmax normaliser: exp words in, exp_i/sum probabilities out
// Purpose: collects up to N_MAX {pos, mant} exp words, sums their linearised values,
//   then emits each lin_i/sum as Q0.16 (saturated to all-ones at 1.0).
// Ports: clk, rst (sync active-high); bus (softmax_norm_if.slave: in_* input stream,
//   out_* output stream); busy (state != IDLE);
//   ovf (only with SOFTMAX_NORM_OVF_EN: one-cycle pulse when a full buffer forces last).
module softmax_norm
   import softmax_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   softmax_norm_if.slave  bus,
   output logic           busy
`ifdef SOFTMAX_NORM_OVF_EN
   ,
   output logic           ovf
`endif
);
   norm_state_e      r_state;
   exp_word_t        r_buf [N_MAX];
   logic [ACC_W-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_rd;
   logic             r_div_pend;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_last;

   exp_word_t        w_in_word;
   logic [LIN_W-1:0] w_in_lin;
   logic             w_in_ready;
   logic             w_in_hs;
   logic             w_wr_en;
   logic [IDX_W-1:0] w_wr_idx;
   logic             w_full;
   logic             w_rd_last;
   logic             w_sum_zero;
   logic             w_div_start;
   logic [DVD_W-1:0] w_dividend;
   logic             w_div_done;
   logic [Q_W-1:0]   w_div_q;

   assign w_in_word  = exp_word_t'(bus.in_data);
   assign w_in_lin   = lin_of(w_in_word);
   // Gated by rst so the block refuses input during the reset cycle itself.
   assign w_in_ready = ~rst & ((r_state == ST_IDLE) || (r_state == ST_COLLECT));
   assign w_in_hs    = bus.in_valid & w_in_ready;
   assign w_wr_en    = w_in_hs;
   assign w_wr_idx   = (r_state == ST_IDLE) ? '0 : r_cnt[IDX_W-1:0];
   // Element being accepted now is the N_MAX-th one.
   assign w_full     = (r_cnt == CNT_W'(N_MAX - 1));
   assign w_rd_last  = ({1'b0, r_rd} == (r_cnt - CNT_W'(1)));
   assign w_sum_zero = (r_sum == '0);
   assign w_div_start = (r_state == ST_DIVIDE) && r_div_pend && !w_sum_zero;
   // Raw words are buffered; linearisation is recomputed here on read.
   assign w_dividend = {lin_of(r_buf[r_rd]), {OUT_W{1'b0}}};

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_buf[w_wr_idx] <= w_in_word;
      end
   end

   seq_divider #(
      .DVD_W (DVD_W),
      .DSR_W (ACC_W),
      .Q_W   (Q_W)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_div_start),
      .i_dividend (w_dividend),
      .i_divisor  (r_sum),
      .o_done     (w_div_done),
      .o_quotient (w_div_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_rd        <= '0;
         r_div_pend  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_in_hs) begin
                  r_sum <= ACC_W'(w_in_lin);
                  r_cnt <= CNT_W'(1);
                  r_rd  <= '0;
                  if (bus.in_last) begin
                     r_state    <= ST_DIVIDE;
                     r_div_pend <= 1'b1;
                  end else begin
                     r_state <= ST_COLLECT;
                  end
               end
            end
            ST_COLLECT: begin
               if (w_in_hs) begin
                  r_sum <= r_sum + ACC_W'(w_in_lin);
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (bus.in_last || w_full) begin
                     r_state    <= ST_DIVIDE;
                     r_rd       <= '0;
                     r_div_pend <= 1'b1;
                  end
               end
            end
            ST_DIVIDE: begin
               if (r_div_pend) begin
                  // First DIVIDE cycle: the divider is started combinationally,
                  // or bypassed entirely when every element is zero.
                  r_div_pend <= 1'b0;
                  if (w_sum_zero) begin
                     r_out_data  <= '0;
                     r_out_last  <= w_rd_last;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_EMIT;
                  end
               end else if (w_div_done) begin
                  r_out_data  <= w_div_q[OUT_W] ? '1 : w_div_q[OUT_W-1:0];
                  r_out_last  <= w_rd_last;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_out_last) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_rd       <= r_rd + IDX_W'(1);
                     r_div_pend <= 1'b1;
                     r_state    <= ST_DIVIDE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SOFTMAX_NORM_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= (r_state == ST_COLLECT) && w_in_hs && !bus.in_last && w_full;
      end
   end

   assign ovf = r_ovf;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_softmax_norm.sv
// tb/tb_softmax_norm.sv - self-checking bench for softmax_norm
module tb_softmax_norm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
`ifdef SOFTMAX_NORM_OVF_EN
   logic ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [20:0] vq[$];

   softmax_norm_if bus();

   softmax_norm dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
`ifdef SOFTMAX_NORM_OVF_EN
      ,
      .ovf  (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned lin_w(input logic [20:0] w);
      return 64'(w[15:0]) << w[20:16];
   endfunction

   // Reference: floor(lin*2^16/sum), saturated to 0xFFFF, zero when sum is zero.
   function automatic logic [15:0] ref_prob(input longint unsigned lin, input longint unsigned sum);
      longint unsigned q;
      if (sum == 0) return 16'h0;
      q = (lin << 16) / sum;
      if (q > 64'd65535) return 16'hFFFF;
      return q[15:0];
   endfunction

   task automatic send_word(input logic [20:0] w, input logic last);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      bus.in_last  = last;
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) check("in_timeout", 0, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_vec(input int n, input bit with_last, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_word(vq[i], with_last && (i == n - 1));
      end
   endtask

   task automatic recv(input string tag, input logic [15:0] exp_d, input logic exp_l, input int hold);
      int t = 0;
      while (!bus.out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.out_valid) begin
         check({tag, "_timeout"}, 0, 1);
         return;
      end
      check({tag, "_data"}, bus.out_data, exp_d);
      check({tag, "_last"}, bus.out_last, exp_l);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, "_hold_data"}, bus.out_data, exp_d);
         check({tag, "_hold_last"}, bus.out_last, exp_l);
         check({tag, "_hold_in_ready"}, bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   // Expects outputs for vq[0..n-1]; hold_len stalls out_ready on element hold_idx,
   // hold_idx < 0 means random short stalls everywhere.
   task automatic expect_vec(input string tag, input int n, input int hold_idx, input int hold_len);
      longint unsigned sum = 0;
      int hold;
      for (int i = 0; i < n; i++) sum += lin_w(vq[i]);
      for (int i = 0; i < n; i++) begin
         if (hold_idx < 0) hold = $urandom_range(0, 2);
         else hold = (i == hold_idx) ? hold_len : 0;
         recv($sformatf("%s_e%0d", tag, i), ref_prob(lin_w(vq[i]), sum), i == n - 1, hold);
      end
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_in_ready_end"}, bus.in_ready, 1);
   endtask

   initial begin
      bit seen;
      int n;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_busy", busy, 0);
`ifdef SOFTMAX_NORM_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_in_ready", bus.in_ready, 1);

      // Four equal words -> quarter each
      vq = '{21'h108000, 21'h108000, 21'h108000, 21'h108000};
      send_vec(4, 1, 0);
      expect_vec("quad", 4, -1, 0);

      // Single word saturates to 1.0
      vq = '{21'h031234};
      send_vec(1, 1, 0);
      expect_vec("single", 1, -1, 0);

      // 3:1 split
      vq = '{21'h000003, 21'h000001};
      send_vec(2, 1, 0);
      expect_vec("split", 2, -1, 0);

      // Largest words, no accumulator overflow
      vq = '{21'h1FFFFF, 21'h1FFFFF};
      send_vec(2, 1, 0);
      expect_vec("maxw", 2, -1, 0);

      // All-zero mantissas bypass the divider
      vq = '{21'h000000, 21'h050000, 21'h1F0000};
      send_vec(3, 1, 0);
      expect_vec("zero", 3, -1, 0);

      // Long backpressure on the middle element
      vq = '{21'h021000, 21'h004000, 21'h012000};
      send_vec(3, 1, 0);
      expect_vec("hold", 3, 1, 10);

      // Buffer full: 16 words without last, then elements 17/18 form the next vector
      vq.delete();
      for (int i = 0; i < 18; i++) vq.push_back({5'($urandom_range(0, 8)), 16'($urandom_range(1, 65535))});
      send_vec(16, 0, 0);
      check("full_in_ready", bus.in_ready, 0);
      check("full_busy", busy, 1);
`ifdef SOFTMAX_NORM_OVF_EN
      check("full_ovf_pulse", ovf, 1);
      @(negedge clk);
      check("full_ovf_clear", ovf, 0);
`endif
      expect_vec("full", 16, -1, 0);
      vq = vq[16:17];
      send_vec(2, 1, 0);
      expect_vec("after_full", 2, -1, 0);

      // Reset in the middle of DIVIDE
      vq = '{21'h0A1234, 21'h05ABCD};
      send_vec(2, 1, 0);
      repeat (7) @(negedge clk);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_busy", busy, 0);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check("mid_rst_no_output", seen, 0);
      vq = '{21'h0300FF, 21'h020400};
      send_vec(2, 1, 0);
      expect_vec("post_rst", 2, -1, 0);

      // Randomized vectors against the reference model
      for (int v = 0; v < 24; v++) begin
         n = $urandom_range(1, 16);
         vq.delete();
         for (int i = 0; i < n; i++) begin
            logic [15:0] m;
            m = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            vq.push_back({5'($urandom_range(0, 31)), m});
         end
         send_vec(n, 1, 1);
         expect_vec($sformatf("rnd%0d", v), n, -1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
